// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs req/ack reads against instruction
// memory, and presents {PC+4, instruction} to the IF/ID register.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'hFC00_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hd_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] hold_inst_r;
    logic [31:0] hold_addr_r;
    logic [31:0] inst_r;
    logic [31:0] inst_addr_r;
    logic        inst_valid_r;
    logic        mem_req_r;
    logic [31:0] mem_addr_r;
    logic [31:0] pc_plus4_s;

    // Sequential PC increment, wraps modulo 2^32.
    always_comb begin
        pc_plus4_s = 32'h0000_0000;
        pc_plus4_s = pc_r + 32'd4;
    end

    // Fetch FSM; mem_addr_r keeps the old address while draining an abandoned read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            hold_inst_r  <= 32'h0000_0000;
            hold_addr_r  <= 32'h0000_0000;
            inst_r       <= BUBBLE;
            inst_addr_r  <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= RESET_PC;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_REQ;
                    mem_req_r  <= 1'b1;
                    mem_addr_r <= pc_r;
                end
                ST_REQ: begin
                    if (redirect_i) begin
                        pc_r         <= redirect_addr_i;
                        inst_r       <= BUBBLE;
                        inst_valid_r <= 1'b0;
                        if (mem_ack_i) begin
                            mem_addr_r <= redirect_addr_i;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end else if (hd_i) begin
                        if (mem_ack_i) begin
                            hold_inst_r <= mem_data_i;
                            hold_addr_r <= pc_plus4_s;
                            pc_r        <= pc_plus4_s;
                            mem_addr_r  <= pc_plus4_s;
                            mem_req_r   <= 1'b0;
                            state_r     <= ST_HOLD;
                        end
                    end else if (mem_ack_i) begin
                        inst_r       <= mem_data_i;
                        inst_addr_r  <= pc_plus4_s;
                        inst_valid_r <= 1'b1;
                        pc_r         <= pc_plus4_s;
                        mem_addr_r   <= pc_plus4_s;
                    end else begin
                        inst_r       <= BUBBLE;
                        inst_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect_i) begin
                        pc_r         <= redirect_addr_i;
                        mem_addr_r   <= redirect_addr_i;
                        inst_r       <= BUBBLE;
                        inst_valid_r <= 1'b0;
                        mem_req_r    <= 1'b1;
                        state_r      <= ST_REQ;
                    end else if (!hd_i) begin
                        inst_r       <= hold_inst_r;
                        inst_addr_r  <= hold_addr_r;
                        inst_valid_r <= 1'b1;
                        mem_addr_r   <= pc_r;
                        mem_req_r    <= 1'b1;
                        state_r      <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    inst_r       <= BUBBLE;
                    inst_valid_r <= 1'b0;
                    if (redirect_i) begin
                        pc_r <= redirect_addr_i;
                    end
                    if (mem_ack_i) begin
                        mem_addr_r <= redirect_i ? redirect_addr_i : pc_r;
                        state_r    <= ST_REQ;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    inst_r       <= BUBBLE;
                    inst_valid_r <= 1'b0;
                    mem_req_r    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o    = mem_req_r;
    assign mem_addr_o   = mem_addr_r;
    assign inst_o       = inst_r;
    assign inst_addr_o  = inst_addr_r;
    assign inst_valid_o = inst_valid_r;

endmodule
